// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder that consumes DIGIT bits per clock with valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b) and the signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] sum_next;
`ifdef SERIAL_ADDER_SUB_EN
  logic             msb_cin;
`endif

  // New digits enter at the MSB end, so after NDIG steps the sum is fully aligned.
  always_comb begin
    digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
    sum_next  = (sum >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
  always_comb begin
    msb_cin = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ digit_sum[DIGIT-1];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      count     <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
`ifdef SERIAL_ADDER_SUB_EN
            b_sh     <= sub ? ~b : b;
            carry    <= sub | cin;
`else
            b_sh     <= b;
            carry    <= cin;
`endif
            count    <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          sum   <= sum_next;
          carry <= digit_sum[DIGIT];
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          count <= count + 1'b1;
          if (count == LAST) begin
            cout      <= digit_sum[DIGIT];
`ifdef SERIAL_ADDER_SUB_EN
            ovf       <= msb_cin ^ digit_sum[DIGIT];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
